// File: rtl/atree_pkg.sv
// Shared definitions for the adder tree and its stream loader.
package atree_pkg;

   typedef enum logic {FILL, FULL} state_t;

   function automatic int unsigned lanes(input int unsigned levels);
      return 32'(1) << levels;
   endfunction

   function automatic int unsigned sum_w(input int unsigned in_width, input int unsigned levels);
      return in_width + levels;
   endfunction

endpackage

// File: rtl/atree_loader.sv
// Stream-to-parallel loader: packs 2**LEVELS samples into one frame for atree.
// Optional partial-frame close enabled by ATREE_LOADER_FLUSH_EN.
module atree_loader
   import atree_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned LEVELS   = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [IN_WIDTH-1:0]                  in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
`ifdef ATREE_LOADER_FLUSH_EN
   input  logic                                 flush,
`endif
   output logic [lanes(LEVELS)*IN_WIDTH-1:0]    out_vec
);

   localparam int unsigned LANES = lanes(LEVELS);
   localparam int unsigned VEC_W = LANES * IN_WIDTH;

   state_t              state, state_n;
   logic [LEVELS-1:0]   cnt, cnt_n;
   logic [VEC_W-1:0]    vec_n;
   logic                accept;
   logic [LEVELS-1:0]   wr_idx;
   logic                do_flush;
   int                  zero_from;

   // Ready passes through from downstream while a frame is held.
   assign in_ready  = !rst && ((state == FILL) || out_ready);
   assign out_valid = (state == FULL);
   assign accept    = in_valid && in_ready;
   assign wr_idx    = (state == FULL) ? '0 : cnt;

`ifdef ATREE_LOADER_FLUSH_EN
   assign do_flush  = flush && (state == FILL) && ((cnt != '0) || accept);
`else
   assign do_flush  = 1'b0;
`endif
   assign zero_from = int'(cnt) + (accept ? 1 : 0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FILL;
         cnt     <= '0;
         out_vec <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         out_vec <= vec_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      vec_n   = out_vec;

      // Lane write decoder; flush zero-pads lanes after the last real sample.
      for (int k = 0; k < int'(LANES); k++) begin
         if (accept && (LEVELS'(k) == wr_idx))
            vec_n[k*IN_WIDTH +: IN_WIDTH] = in_data;
         else if (do_flush && (k >= zero_from))
            vec_n[k*IN_WIDTH +: IN_WIDTH] = '0;
      end

      case (state)
         FILL: begin
            if (accept) begin
               cnt_n = cnt + LEVELS'(1);
               if (cnt == LEVELS'(LANES - 1))
                  state_n = FULL;
            end
            if (do_flush) begin
               cnt_n   = '0;
               state_n = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               state_n = FILL;
               cnt_n   = accept ? LEVELS'(1) : '0;
            end
         end
         default: begin
            state_n = FILL;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: doc/atree_loader.md
Name: atree_loader

Overview:
Stream-to-parallel front end for the adder tree. It accepts one IN_WIDTH sample per valid/ready handshake and packs 2**LEVELS samples into the packed lane vector that atree consumes. It then holds the full frame under a valid/ready output handshake until downstream accepts it. It sits directly upstream of atree; its out_vec connects to atree.inputs unchanged.

Parameters:
IN_WIDTH, 8, width of one sample / one tree lane (unsigned)
LEVELS, 2, tree depth; LANES = 2**LEVELS lanes per frame (LEVELS >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data holds a sample
in_ready  output  1  loader can accept a sample this cycle
in_data  input  IN_WIDTH  sample
out_valid  output  1  out_vec holds a complete frame
out_ready  input  1  downstream accepts frame this cycle
out_vec  output  LANES*IN_WIDTH  packed frame; lane k = bits [k*IN_WIDTH +: IN_WIDTH]
flush  input  1  (only with ATREE_LOADER_FLUSH_EN) close partial frame

Behaviour:
- Reset, sampled on clk edge while rst=1: state=FILL, lane counter cnt=0, out_valid=0, out_vec=0. in_ready=0 while rst=1 and 1 in the first cycle after release.
- Counter cnt is LEVELS bits wide and indexes the next lane to write. The first accepted sample of a frame goes to lane 0 (LSBs), the last to lane LANES-1.
- States:
  - FILL: in_ready=1, out_valid=0. Accept on in_valid&in_ready. The accept writes in_data to lane cnt and increments cnt. An accept with cnt==LANES-1 wraps cnt to 0 and moves to FULL.
  - FULL: out_valid=1; out_vec is stable while out_valid=1 and out_ready=0. in_ready=out_ready (pass-through), so one sample may be accepted in the same cycle the frame is taken.
    - out_ready=1 with no input accept: go to FILL, cnt=0.
    - out_ready=1 with input accept: that sample goes to lane 0 and the next state is FILL with cnt=1. No bubble; sustained throughput is one sample per cycle and one frame per LANES cycles.
- Latency: out_valid rises the cycle after the accept of the LANES-th sample.
- Lanes not yet written in FILL keep stale data. out_vec is defined only while out_valid=1.
- in_valid without in_ready: no state change; the sample is not consumed. in_data is ignored when in_valid=0.
- rst mid-frame: partial data is discarded and the next accepted sample lands in lane 0. rst in FULL drops out_valid on the next edge; the frame is lost.
- No signed interpretation; samples are copied bit-exact.

Optional Feature:
ATREE_LOADER_FLUSH_EN
- Defined: the flush port exists. flush=1 in FILL with cnt>0 zero-fills lanes cnt..LANES-1 (plus lane cnt gets in_data if a sample is accepted the same cycle, and zeros start after it), then goes to FULL.
  - flush with cnt==0 and no accept: ignored.
  - flush in FULL: ignored.
  - The zero pad leaves the tree sum equal to the sum of the real samples.
- Undefined: the flush port is absent and only full frames are emitted.

Decomposition:
- Shared package atree_pkg:
  - lane-count function lanes(LEVELS)=2**LEVELS;
  - sum width function sum_w(IN_WIDTH,LEVELS)=IN_WIDTH+LEVELS, which atree also uses;
  - state enum typedef {FILL, FULL}.
- No sub-module. The lane write enable is a decoder of cnt kept inline.
- The top-level bench instantiates atree_loader feeding atree.

Test Plan:
1. LEVELS=2, IN_WIDTH=8, out_ready=1: stream 9,37,42,65 on consecutive cycles -> one cycle after the 4th accept, out_valid=1 and out_vec=0x412A2509; atree out=153.
2. Back-pressure: after a frame completes, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_vec unchanged all 5 cycles. Raise out_ready -> frame taken and the concurrent sample lands in lane 0.
3. Back-to-back: out_ready=1, 8 samples 1..8 on 8 consecutive cycles -> frames 0x04030201 then 0x08070605, 4 cycles apart, in_ready never 0.
4. Reset mid-fill: accept 0xAA, 0xBB, assert rst one cycle, then stream 1,2,3,4 -> single frame 0x04030201; no frame containing 0xAA.
5. LEVELS=4: sixteen 0xFF samples -> out_vec all ones (128 bits); atree out=0xFF0.
6. (FLUSH_EN) Accept 1,2 then flush=1 with in_valid=0 -> next cycle out_valid=1, out_vec=0x00000201, atree out=3.
